// File: rtl/fft_sched_if.sv
// Scheduler <-> butterfly datapath bundle. The cycle_cnt wire exists only when
// FFT_SCHED_PERF_EN is defined.
interface fft_sched_if #(
    parameter int N = 8192
);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(N / 2);
    localparam int S  = $clog2(N);
    localparam int SW = $clog2(S);

    logic          start;
    logic          stall;
    logic          rd_valid;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [KW-1:0] k;
    logic [SW-1:0] stage;
    logic          wr_valid;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic          busy;
    logic          done;
`ifdef FFT_SCHED_PERF_EN
    logic [31:0]   cycle_cnt;
`endif

    modport master (
        input  start, stall,
        output rd_valid, rd_addr_a, rd_addr_b, k, stage,
               wr_valid, wr_addr_a, wr_addr_b, busy, done
`ifdef FFT_SCHED_PERF_EN
        , cycle_cnt
`endif
    );

    modport slave (
        output start, stall,
        input  rd_valid, rd_addr_a, rd_addr_b, k, stage,
               wr_valid, wr_addr_a, wr_addr_b, busy, done
`ifdef FFT_SCHED_PERF_EN
        , cycle_cnt
`endif
    );
endinterface

// File: rtl/fft_sched.sv
// In-place radix-2 DIF butterfly scheduler with delayed write-back and inter-stage flush.
// Optional FFT_SCHED_PERF_EN adds a busy-cycle counter (bus.cycle_cnt).
module fft_sched #(
    parameter int N       = 8192,
    parameter int LATENCY = 4
) (
    input logic         clk,
    input logic         rst_n,
    fft_sched_if.master bus
);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(N / 2);
    localparam int S  = $clog2(N);
    localparam int SW = $clog2(S);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                     state;
    logic [SW-1:0]              s;
    logic [KW-1:0]              j;
    logic                       done_q;
    logic                       run;
    logic                       issue;
    logic                       last_wr;
    logic [AW-1:0]              span;
    logic [AW-1:0]              p;
    logic [AW-1:0]              g;
    logic [AW-1:0]              addr_a;
    logic [AW-1:0]              addr_b;
    logic [KW-1:0]              kk;
    logic [LATENCY-1:0]         pv;
    logic [LATENCY-1:0][AW-1:0] pa;
    logic [LATENCY-1:0][AW-1:0] pb;

    assign run   = (state == RUN);
    assign issue = run & ~bus.stall;

    // Butterfly j of stage s: group g of width 2*span, offset p inside the group.
    always_comb begin
        span   = AW'(32'(N) >> (32'(s) + 1));
        p      = AW'(j) & (span - AW'(1));
        g      = AW'(j) >> (S - 1 - 32'(s));
        addr_a = (g << (S - 32'(s))) + p;
        addr_b = addr_a + span;
        kk     = KW'(p << s);
    end

    // Addresses are forced to zero outside RUN so idle pipeline slots carry zeros.
    assign bus.rd_valid  = issue;
    assign bus.rd_addr_a = run ? addr_a : '0;
    assign bus.rd_addr_b = run ? addr_b : '0;
    assign bus.k         = run ? kk : '0;
    assign bus.stage     = s;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.wr_valid  = pv[LATENCY-1] & ~bus.stall;
    assign bus.wr_addr_a = pa[LATENCY-1];
    assign bus.wr_addr_b = pb[LATENCY-1];
    assign last_wr       = bus.wr_valid & ~(|pv[LATENCY-2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pa <= '0;
            pb <= '0;
        end else if (!bus.stall) begin
            pv <= {pv[LATENCY-2:0], issue};
            pa <= {pa[LATENCY-2:0], bus.rd_addr_a};
            pb <= {pb[LATENCY-2:0], bus.rd_addr_b};
        end
    end

    // IDLE ignores stall so a start under stall is still taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            j      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s     <= '0;
                        j     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (j == KW'(N / 2 - 1)) state <= FLUSH;
                        else                     j     <= j + KW'(1);
                    end
                end
                FLUSH: begin
                    if (last_wr) begin
                        j <= '0;
                        if (s == SW'(S - 1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            s     <= s + SW'(1);
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FFT_SCHED_PERF_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cnt <= '0;
        else if (state == IDLE && bus.start) cnt <= '0;
        else if (state != IDLE)            cnt <= cnt + 32'd1;
    end

    assign bus.cycle_cnt = cnt;
`endif
endmodule

// File: tb/tb_fft_sched.sv
// Randomised and directed checks of fft_sched against a stage/group/offset
// enumeration model (N=8/LATENCY=4 and N=16/LATENCY=2 instances).
module tb_fft_sched;
    localparam int N8  = 8;
    localparam int L8  = 4;
    localparam int N16 = 16;
    localparam int L16 = 2;
    localparam int MAXC = 200;

    typedef struct { int c; int a; int b; int k; int s; } bf_t;
    typedef struct { int c; int t; int a; int b; int k; int s; } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_sched_if #(.N(N8))  b8 ();
    fft_sched_if #(.N(N16)) b16 ();

    fft_sched #(.N(N8), .LATENCY(L8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    fft_sched #(.N(N16), .LATENCY(L16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );

    int  n_cmp = 0;
    int  n_err = 0;
    bf_t mdl[$];
    bf_t exp8[$];
    bf_t exp16[$];
    ev_t iss[$];
    ev_t wr[$];
    int  dones[$];
    int  zero_viol;
    bit  stall_at[MAXC];
    bit  start_at[MAXC];
    int  rst_lo;
    int  rst_hi;

    // Enumerate butterflies stage by stage, group by group, offset by offset.
    task automatic build_model(input int n, input int lat);
        int nst;
        nst = $clog2(n);
        mdl.delete();
        for (int s = 0; s < nst; s++) begin
            int span;
            int idx;
            span = n >> (s + 1);
            idx  = 0;
            for (int g = 0; g < n / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    bf_t e;
                    e.s = s;
                    e.a = g * 2 * span + p;
                    e.b = e.a + span;
                    e.k = p * (1 << s);
                    e.c = 1 + s * (n / 2 + lat) + idx;
                    idx++;
                    mdl.push_back(e);
                end
            end
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            stall_at[i] = 1'b0;
            start_at[i] = 1'b0;
        end
        rst_lo = -1;
        rst_hi = -1;
    endtask

    // Drive the N=8 instance from the stimulus tables and record what it does.
    task automatic run8(input int ncyc);
        int tick;
        tick = 0;
        iss.delete();
        wr.delete();
        dones.delete();
        zero_viol = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rst_n    = !(c >= rst_lo && c < rst_hi);
            b8.start = start_at[c];
            b8.stall = stall_at[c];
            @(negedge clk);
            if (b8.rd_valid) begin
                ev_t e;
                e.c = c; e.t = tick; e.s = int'(b8.stage); e.k = int'(b8.k);
                e.a = int'(b8.rd_addr_a); e.b = int'(b8.rd_addr_b);
                iss.push_back(e);
            end
            if (b8.wr_valid) begin
                ev_t e;
                e.c = c; e.t = tick; e.s = 0; e.k = 0;
                e.a = int'(b8.wr_addr_a); e.b = int'(b8.wr_addr_b);
                wr.push_back(e);
            end
            if (b8.done) dones.push_back(c);
            if (!rst_n && (b8.rd_valid || b8.wr_valid || b8.busy || b8.done ||
                           b8.stage != 0 || b8.rd_addr_a != 0 || b8.rd_addr_b != 0 ||
                           b8.k != 0 || b8.wr_addr_a != 0 || b8.wr_addr_b != 0))
                zero_viol++;
            if (!b8.stall) tick++;
        end
        b8.start = 1'b0;
        b8.stall = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        b8.start  = 1'b0; b8.stall  = 1'b0;
        b16.start = 1'b0; b16.stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({b8.rd_valid, b8.wr_valid, b8.busy, b8.done} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags got rv=%b wv=%b busy=%b done=%b want 0000",
                     b8.rd_valid, b8.wr_valid, b8.busy, b8.done);
        end
        n_cmp++;
        if ({b8.rd_addr_a, b8.rd_addr_b, b8.wr_addr_a, b8.wr_addr_b, b8.k, b8.stage} !== '0) begin
            n_err++;
            $display("FAIL reset_addr got a=%0d b=%0d wa=%0d wb=%0d k=%0d st=%0d want all 0",
                     b8.rd_addr_a, b8.rd_addr_b, b8.wr_addr_a, b8.wr_addr_b, b8.k, b8.stage);
        end
        n_cmp++;
        if ({b16.busy, b16.done, b16.rd_valid} !== 3'b0) begin
            n_err++;
            $display("FAIL reset_n16 got busy=%b done=%b rv=%b want 000", b16.busy, b16.done, b16.rd_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b8.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got busy=%b want 0", b8.busy);
        end
    endtask

    task automatic test_stage_sequence();
        clear_stim();
        start_at[0] = 1'b1;
        run8(40);
        n_cmp++;
        if (iss.size() != exp8.size()) begin
            n_err++;
            $display("FAIL seq_count got %0d want %0d", iss.size(), exp8.size());
        end
        for (int i = 0; i < iss.size() && i < exp8.size(); i++) begin
            n_cmp++;
            if (iss[i].a != exp8[i].a || iss[i].b != exp8[i].b || iss[i].k != exp8[i].k ||
                iss[i].s != exp8[i].s || iss[i].c != exp8[i].c) begin
                n_err++;
                $display("FAIL seq[%0d] got c=%0d a=%0d b=%0d k=%0d s=%0d want c=%0d a=%0d b=%0d k=%0d s=%0d",
                         i, iss[i].c, iss[i].a, iss[i].b, iss[i].k, iss[i].s,
                         exp8[i].c, exp8[i].a, exp8[i].b, exp8[i].k, exp8[i].s);
            end
        end
        n_cmp++;
        if (dones.size() != 1 || dones[0] != 25) begin
            n_err++;
            $display("FAIL seq_done got count=%0d first=%0d want one at 25",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
    endtask

    task automatic test_write_alignment();
        clear_stim();
        start_at[0] = 1'b1;
        run8(40);
        n_cmp++;
        if (wr.size() != 12) begin
            n_err++;
            $display("FAIL wr_count got %0d want 12", wr.size());
        end
        for (int i = 0; i < wr.size() && i < iss.size(); i++) begin
            n_cmp++;
            if (wr[i].a != iss[i].a || wr[i].b != iss[i].b || wr[i].c != iss[i].c + L8) begin
                n_err++;
                $display("FAIL wr[%0d] got c=%0d a=%0d b=%0d want c=%0d a=%0d b=%0d",
                         i, wr[i].c, wr[i].a, wr[i].b, iss[i].c + L8, iss[i].a, iss[i].b);
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (wr.size() == 12 && iss.size() == 12) begin
                n_cmp++;
                if (wr[(s + 1) * 4 - 1].c >= iss[(s + 1) * 4].c) begin
                    n_err++;
                    $display("FAIL stage_order[%0d] got last_wr=%0d next_rd=%0d want last_wr < next_rd",
                             s, wr[(s + 1) * 4 - 1].c, iss[(s + 1) * 4].c);
                end
            end
        end
    endtask

    task automatic test_stall();
        int bad;
        clear_stim();
        start_at[0] = 1'b1;
        for (int c = 2; c <= 4; c++) stall_at[c] = 1'b1;
        stall_at[17] = 1'b1;
        stall_at[18] = 1'b1;
        run8(45);
        bad = 0;
        foreach (iss[i]) if (stall_at[iss[i].c]) bad++;
        foreach (wr[i])  if (stall_at[wr[i].c])  bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_activity got %0d events on stalled cycles want 0", bad);
        end
        n_cmp++;
        if (iss.size() != 12 || wr.size() != 12) begin
            n_err++;
            $display("FAIL stall_counts got rd=%0d wr=%0d want 12/12", iss.size(), wr.size());
        end
        for (int i = 0; i < iss.size() && i < exp8.size(); i++) begin
            n_cmp++;
            if (iss[i].a != exp8[i].a || iss[i].b != exp8[i].b || iss[i].k != exp8[i].k) begin
                n_err++;
                $display("FAIL stall_seq[%0d] got a=%0d b=%0d k=%0d want a=%0d b=%0d k=%0d",
                         i, iss[i].a, iss[i].b, iss[i].k, exp8[i].a, exp8[i].b, exp8[i].k);
            end
        end
        n_cmp++;
        if (dones.size() != 1 || dones[0] != 30) begin
            n_err++;
            $display("FAIL stall_done got count=%0d first=%0d want one at 30",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
    endtask

    task automatic test_ignored_start();
        clear_stim();
        start_at[0]  = 1'b1;
        start_at[10] = 1'b1;
        run8(40);
        n_cmp++;
        if (dones.size() != 1 || dones[0] != 25) begin
            n_err++;
            $display("FAIL ign_start_done got count=%0d first=%0d want one at 25",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
        n_cmp++;
        if (iss.size() != 12 || (iss.size() > 4 && iss[4].c != exp8[4].c)) begin
            n_err++;
            $display("FAIL ign_start_seq got count=%0d want 12 with stage1 at cycle %0d",
                     iss.size(), exp8[4].c);
        end
    endtask

    task automatic test_reset_mid_run();
        ev_t post[$];
        clear_stim();
        start_at[0]  = 1'b1;
        rst_lo       = 12;
        rst_hi       = 14;
        start_at[14] = 1'b1;
        run8(60);
        n_cmp++;
        if (zero_viol != 0) begin
            n_err++;
            $display("FAIL rst_outputs got %0d nonzero cycles want 0", zero_viol);
        end
        n_cmp++;
        if (dones.size() != 1 || dones[0] != 39) begin
            n_err++;
            $display("FAIL rst_done got count=%0d first=%0d want one at 39",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
        foreach (iss[i]) if (iss[i].c >= 14) post.push_back(iss[i]);
        n_cmp++;
        if (post.size() != 12) begin
            n_err++;
            $display("FAIL rst_rerun_count got %0d want 12", post.size());
        end
        for (int i = 0; i < post.size() && i < exp8.size(); i++) begin
            n_cmp++;
            if (post[i].a != exp8[i].a || post[i].b != exp8[i].b || post[i].k != exp8[i].k ||
                post[i].c - 14 != exp8[i].c) begin
                n_err++;
                $display("FAIL rst_rerun[%0d] got c=%0d a=%0d b=%0d k=%0d want c=%0d a=%0d b=%0d k=%0d",
                         i, post[i].c - 14, post[i].a, post[i].b, post[i].k,
                         exp8[i].c, exp8[i].a, exp8[i].b, exp8[i].k);
            end
        end
    endtask

    task automatic test_random_stall();
        for (int r = 0; r < 3; r++) begin
            int nst;
            clear_stim();
            start_at[0] = 1'b1;
            for (int c = 0; c < 150; c++) stall_at[c] = ($urandom_range(0, 3) == 0);
            run8(150);
            n_cmp++;
            if (dones.size() != 1) begin
                n_err++;
                $display("FAIL rnd%0d_done_count got %0d want 1", r, dones.size());
            end else begin
                nst = 0;
                for (int c = 1; c < dones[0]; c++) nst += int'(stall_at[c]);
                n_cmp++;
                if (dones[0] != 25 + nst) begin
                    n_err++;
                    $display("FAIL rnd%0d_done got %0d want %0d", r, dones[0], 25 + nst);
                end
            end
            n_cmp++;
            if (iss.size() != 12 || wr.size() != 12) begin
                n_err++;
                $display("FAIL rnd%0d_counts got rd=%0d wr=%0d want 12/12", r, iss.size(), wr.size());
            end
            for (int i = 0; i < iss.size() && i < exp8.size(); i++) begin
                n_cmp++;
                if (iss[i].a != exp8[i].a || iss[i].b != exp8[i].b || iss[i].k != exp8[i].k ||
                    iss[i].s != exp8[i].s) begin
                    n_err++;
                    $display("FAIL rnd%0d_seq[%0d] got a=%0d b=%0d k=%0d s=%0d want a=%0d b=%0d k=%0d s=%0d",
                             r, i, iss[i].a, iss[i].b, iss[i].k, iss[i].s,
                             exp8[i].a, exp8[i].b, exp8[i].k, exp8[i].s);
                end
            end
            for (int i = 0; i < wr.size() && i < iss.size(); i++) begin
                n_cmp++;
                if (wr[i].a != iss[i].a || wr[i].b != iss[i].b || wr[i].t != iss[i].t + L8) begin
                    n_err++;
                    $display("FAIL rnd%0d_wr[%0d] got tick=%0d a=%0d b=%0d want tick=%0d a=%0d b=%0d",
                             r, i, wr[i].t, wr[i].a, wr[i].b, iss[i].t + L8, iss[i].a, iss[i].b);
                end
            end
        end
    endtask

    task automatic test_perf();
        int dc;
        int nis;
        bit busy_at_done;
`ifdef FFT_SCHED_PERF_EN
        logic [31:0] cnt_done;
        logic [31:0] cnt_late;
        cnt_done = '0;
        cnt_late = '0;
`endif
        dc = -1;
        nis = 0;
        busy_at_done = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            b16.start = (c == 0);
            b16.stall = 1'b0;
            @(negedge clk);
            if (b16.rd_valid) begin
                if (nis < exp16.size()) begin
                    n_cmp++;
                    if (int'(b16.rd_addr_a) != exp16[nis].a || int'(b16.rd_addr_b) != exp16[nis].b ||
                        int'(b16.k) != exp16[nis].k || c != exp16[nis].c) begin
                        n_err++;
                        $display("FAIL n16_seq[%0d] got c=%0d a=%0d b=%0d k=%0d want c=%0d a=%0d b=%0d k=%0d",
                                 nis, c, b16.rd_addr_a, b16.rd_addr_b, b16.k,
                                 exp16[nis].c, exp16[nis].a, exp16[nis].b, exp16[nis].k);
                    end
                end
                nis++;
            end
            if (b16.done && dc < 0) begin
                dc = c;
                busy_at_done = b16.busy;
`ifdef FFT_SCHED_PERF_EN
                cnt_done = b16.cycle_cnt;
`endif
            end
`ifdef FFT_SCHED_PERF_EN
            if (c == 60) cnt_late = b16.cycle_cnt;
`endif
        end
        b16.start = 1'b0;
        n_cmp++;
        if (dc != 41 || busy_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL n16_done got cycle=%0d busy=%b want cycle 41 busy 0", dc, busy_at_done);
        end
        n_cmp++;
        if (nis != 32) begin
            n_err++;
            $display("FAIL n16_count got %0d want 32", nis);
        end
`ifdef FFT_SCHED_PERF_EN
        n_cmp++;
        if (cnt_done !== 32'd40) begin
            n_err++;
            $display("FAIL perf_at_done got %0d want 40", cnt_done);
        end
        n_cmp++;
        if (cnt_late !== 32'd40) begin
            n_err++;
            $display("FAIL perf_hold got %0d want 40", cnt_late);
        end
`endif
    endtask

    initial begin
        build_model(N8, L8);
        exp8 = mdl;
        build_model(N16, L16);
        exp16 = mdl;
        test_reset();
        test_stage_sequence();
        test_write_alignment();
        test_stall();
        test_ignored_start();
        test_reset_mid_run();
        test_random_stall();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
